mem_port_arbiter: RTL and testbench

//  Shares one single-ported, 4-byte-lane synchronous instruction/data RAM between the fetch

---
 rtl/mem_port_arbiter.sv | 147 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one 4-lane RAM between two-word fetch and RV32I LSU accesses.
// Define MEM_ARB_RR_EN for round-robin conflict resolution instead of fixed LSU priority.
module mem_port_arbiter #(
    parameter int ADDR_W = 14
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              io_if_req_valid,
    output logic              io_if_req_ready,
    input  logic [63:0]       io_if_req_addr,
    output logic              io_if_resp_valid,
    output logic [31:0]       io_if_resp_inst_0,
    output logic [31:0]       io_if_resp_inst_1,
    input  logic              io_lsu_req_valid,
    output logic              io_lsu_req_ready,
    input  logic [63:0]       io_lsu_req_addr,
    input  logic              io_lsu_req_we,
    input  logic [31:0]       io_lsu_req_wdata,
    input  logic [2:0]        io_lsu_req_func3,
    output logic              io_lsu_resp_valid,
    output logic [31:0]       io_lsu_resp_data,
    output logic              io_lsu_resp_err,
    output logic              io_mem_en,
    output logic              io_mem_we,
    output logic [3:0]        io_mem_be,
    output logic [ADDR_W-1:0] io_mem_addr,
    output logic [31:0]       io_mem_wdata,
    input  logic [31:0]       io_mem_rdata,
    output logic              io_busy
);
    typedef enum logic [2:0] {IDLE, IF_W1, IF_WAIT, IF_RESP, LD_WAIT, RESP} state_t;
    state_t            r_state;
    logic [ADDR_W-1:0] r_addr;
    logic [1:0]        r_off;
    logic [2:0]        r_f3;
    logic [31:0]       r_inst_0, r_inst_1, r_lsu_data;
    logic              r_if_valid, r_lsu_valid, r_lsu_err;
    logic              w_idle, w_lsu_prio, w_gnt_lsu, w_gnt_if, w_err, w_lsu_acc, w_fetch2, w_st;
    logic [1:0]        w_off;
    logic [2:0]        w_f3;
    logic [3:0]        w_st_be;
    logic [7:0]        w_byte;
    logic [15:0]       w_half;
    logic [31:0]       w_ld;
    logic              w_unused;
`ifdef MEM_ARB_RR_EN
    logic              r_last_lsu;
    assign w_lsu_prio = ~r_last_lsu;
`else
    assign w_lsu_prio = 1'b1;
`endif
    assign w_unused  = ^{io_if_req_addr[63:ADDR_W+2], io_if_req_addr[1:0], io_lsu_req_addr[63:ADDR_W+2]};
    assign w_idle    = (r_state == IDLE) & ~reset;
    assign w_gnt_lsu = w_idle & io_lsu_req_valid & (w_lsu_prio | ~io_if_req_valid);
    assign w_gnt_if  = w_idle & io_if_req_valid & ~w_gnt_lsu;
    assign w_off     = io_lsu_req_addr[1:0];
    assign w_f3      = io_lsu_req_func3;
    // illegal func3 (incl. load-only codes on a store) or natural-alignment violation
    assign w_err     = (w_f3[1:0] == 2'b11) | (w_f3[2] & (io_lsu_req_we | w_f3[1]))
                     | ((w_f3[1:0] == 2'b01) & w_off[0]) | ((w_f3[1:0] == 2'b10) & (|w_off));
    assign w_lsu_acc = w_gnt_lsu & ~w_err;
    assign w_fetch2  = (r_state == IF_W1) & ~reset;
    assign w_st      = w_lsu_acc & io_lsu_req_we;
    assign w_st_be   = w_f3[1] ? 4'b1111 : w_f3[0] ? (w_off[1] ? 4'b1100 : 4'b0011) : 4'b0001 << w_off;
    assign io_mem_en    = w_gnt_if | w_lsu_acc | w_fetch2;
    assign io_mem_we    = w_st;
    assign io_mem_be    = (w_gnt_if | w_fetch2 | (w_lsu_acc & ~io_lsu_req_we)) ? 4'hF : w_st ? w_st_be : 4'h0;
    assign io_mem_addr  = w_fetch2 ? r_addr + {{(ADDR_W-1){1'b0}}, 1'b1}
                        : w_lsu_acc ? io_lsu_req_addr[ADDR_W+1:2]
                        : w_gnt_if ? io_if_req_addr[ADDR_W+1:2] : '0;
    assign io_mem_wdata = ~w_st ? 32'h0 : w_f3[1] ? io_lsu_req_wdata
                        : w_f3[0] ? {2{io_lsu_req_wdata[15:0]}} : {4{io_lsu_req_wdata[7:0]}};
    assign w_byte = io_mem_rdata[{r_off, 3'b000} +: 8];
    assign w_half = r_off[1] ? io_mem_rdata[31:16] : io_mem_rdata[15:0];
    assign w_ld   = r_f3[1] ? io_mem_rdata
                  : r_f3[0] ? {{16{w_half[15] & ~r_f3[2]}}, w_half} : {{24{w_byte[7] & ~r_f3[2]}}, w_byte};
    assign io_if_req_ready   = w_gnt_if;
    assign io_lsu_req_ready  = w_gnt_lsu;
    assign io_if_resp_valid  = r_if_valid;
    assign io_if_resp_inst_0 = r_inst_0;
    assign io_if_resp_inst_1 = r_inst_1;
    assign io_lsu_resp_valid = r_lsu_valid;
    assign io_lsu_resp_data  = r_lsu_data;
    assign io_lsu_resp_err   = r_lsu_err;
    assign io_busy           = r_state != IDLE;
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_addr      <= '0;
            r_off       <= '0;
            r_f3        <= '0;
            r_inst_0    <= '0;
            r_inst_1    <= '0;
            r_lsu_data  <= '0;
            r_if_valid  <= 1'b0;
            r_lsu_valid <= 1'b0;
            r_lsu_err   <= 1'b0;
`ifdef MEM_ARB_RR_EN
            r_last_lsu  <= 1'b0;
`endif
        end else begin
            r_if_valid  <= 1'b0;
            r_lsu_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_gnt_lsu) begin
                        r_off <= w_off;
                        r_f3  <= w_f3;
`ifdef MEM_ARB_RR_EN
                        r_last_lsu <= 1'b1;
`endif
                        if (w_err | io_lsu_req_we) begin
                            r_lsu_valid <= 1'b1;
                            r_lsu_err   <= w_err;
                            r_lsu_data  <= 32'h0;
                            r_state     <= RESP;
                        end else begin
                            r_state <= LD_WAIT;
                        end
                    end else if (w_gnt_if) begin
                        r_addr  <= io_if_req_addr[ADDR_W+1:2];
`ifdef MEM_ARB_RR_EN
                        r_last_lsu <= 1'b0;
`endif
                        r_state <= IF_W1;
                    end
                end
                IF_W1: begin
                    r_inst_0 <= io_mem_rdata;
                    r_state  <= IF_WAIT;
                end
                IF_WAIT: begin
                    r_inst_1   <= io_mem_rdata;
                    r_if_valid <= 1'b1;
                    r_state    <= IF_RESP;
                end
                LD_WAIT: begin
                    r_lsu_data  <= w_ld;
                    r_lsu_err   <= 1'b0;
                    r_lsu_valid <= 1'b1;
                    r_state     <= RESP;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed and randomized checks of mem_port_arbiter against a byte-level memory model.
module tb_mem_port_arbiter;
    localparam int AW = 14;
    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          io_if_req_valid = 1'b0, io_if_req_ready;
    logic [63:0]   io_if_req_addr = '0;
    logic          io_if_resp_valid;
    logic [31:0]   io_if_resp_inst_0, io_if_resp_inst_1;
    logic          io_lsu_req_valid = 1'b0, io_lsu_req_ready;
    logic [63:0]   io_lsu_req_addr = '0;
    logic          io_lsu_req_we = 1'b0;
    logic [31:0]   io_lsu_req_wdata = '0;
    logic [2:0]    io_lsu_req_func3 = '0;
    logic          io_lsu_resp_valid;
    logic [31:0]   io_lsu_resp_data;
    logic          io_lsu_resp_err;
    logic          io_mem_en, io_mem_we;
    logic [3:0]    io_mem_be;
    logic [AW-1:0] io_mem_addr;
    logic [31:0]   io_mem_wdata;
    logic [31:0]   io_mem_rdata;
    logic          io_busy;
    logic [31:0]   ram  [0:(1<<AW)-1];
    logic [31:0]   refm [0:(1<<AW)-1];
    logic          pl_en = 1'b0;
    logic [AW-1:0] pl_a = '0;
    logic [31:0]   pl_d = '0;
    int total = 0, bad = 0;

    mem_port_arbiter #(.ADDR_W(AW)) dut (
        .clock(clock), .reset(reset),
        .io_if_req_valid(io_if_req_valid), .io_if_req_ready(io_if_req_ready), .io_if_req_addr(io_if_req_addr),
        .io_if_resp_valid(io_if_resp_valid), .io_if_resp_inst_0(io_if_resp_inst_0), .io_if_resp_inst_1(io_if_resp_inst_1),
        .io_lsu_req_valid(io_lsu_req_valid), .io_lsu_req_ready(io_lsu_req_ready), .io_lsu_req_addr(io_lsu_req_addr),
        .io_lsu_req_we(io_lsu_req_we), .io_lsu_req_wdata(io_lsu_req_wdata), .io_lsu_req_func3(io_lsu_req_func3),
        .io_lsu_resp_valid(io_lsu_resp_valid), .io_lsu_resp_data(io_lsu_resp_data), .io_lsu_resp_err(io_lsu_resp_err),
        .io_mem_en(io_mem_en), .io_mem_we(io_mem_we), .io_mem_be(io_mem_be), .io_mem_addr(io_mem_addr),
        .io_mem_wdata(io_mem_wdata), .io_mem_rdata(io_mem_rdata), .io_busy(io_busy)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (pl_en) ram[pl_a] <= pl_d;
        else if (io_mem_en) begin
            if (io_mem_we) begin
                for (int i = 0; i < 4; i++) if (io_mem_be[i]) ram[io_mem_addr][8*i +: 8] <= io_mem_wdata[8*i +: 8];
            end else io_mem_rdata <= ram[io_mem_addr];
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic fetch(input string tag, input logic [63:0] addr);
        logic [AW-1:0] a, a1;
        logic [31:0] i0, i1;
        int lat, cnt, n;
        a = addr[AW+1:2];
        a1 = AW'(a + 1);
        i0 = 'x; i1 = 'x; lat = 0; cnt = 0; n = 0;
        @(negedge clock);
        io_if_req_valid = 1'b1;
        io_if_req_addr = addr;
        #1;
        while (!io_if_req_ready && n < 20) begin @(negedge clock); #1; n++; end
        chk({tag, " grant"}, io_if_req_ready, 1);
        chk({tag, " rd0"}, {io_mem_en, io_mem_we, io_mem_be, io_mem_addr}, {1'b1, 1'b0, 4'hF, a});
        for (int k = 1; k <= 6; k++) begin
            @(negedge clock);
            io_if_req_valid = 1'b0;
            if (k == 1) chk({tag, " rd1"}, {io_mem_en, io_mem_we, io_mem_be, io_mem_addr}, {1'b1, 1'b0, 4'hF, a1});
            if (io_if_resp_valid) begin
                cnt++;
                if (lat == 0) begin lat = k; i0 = io_if_resp_inst_0; i1 = io_if_resp_inst_1; end
            end
        end
        chk({tag, " lat"}, lat, 3);
        chk({tag, " pulses"}, cnt, 1);
        chk({tag, " inst0"}, i0, refm[a]);
        chk({tag, " inst1"}, i1, refm[a1]);
    endtask

    task automatic lsu(input string tag, input logic [63:0] addr, input bit we, input logic [2:0] f3, input logic [31:0] wd);
        logic [AW-1:0] a;
        logic [31:0] w, v, mask, exp_wd, d;
        logic [3:0] exp_be;
        int nb, off, lat, cnt, n;
        bit err, en_seen, e;
        a = addr[AW+1:2];
        off = int'(addr[1:0]);
        nb = 1 << f3[1:0];
        err = we ? (f3 > 3'd2) : !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        err = err || (off % nb) != 0;
        w = refm[a];
        mask = (32'h1 << (8 * nb)) - 32'h1;
        v = (w >> (8 * off)) & mask;
        if (!f3[2] && nb < 4 && v[8*nb-1]) v = v | ~mask;
        exp_be = we ? 4'(((1 << nb) - 1) << off) : 4'hF;
        for (int j = 0; j < 4; j++) exp_wd[8*j +: 8] = wd[8*(j % nb) +: 8];
        lat = 0; cnt = 0; n = 0; en_seen = 0; d = 'x; e = 1'bx;
        @(negedge clock);
        io_lsu_req_valid = 1'b1;
        io_lsu_req_addr = addr;
        io_lsu_req_we = we;
        io_lsu_req_func3 = f3;
        io_lsu_req_wdata = wd;
        #1;
        while (!io_lsu_req_ready && n < 20) begin @(negedge clock); #1; n++; end
        chk({tag, " grant"}, io_lsu_req_ready, 1);
        chk({tag, " en"}, io_mem_en, !err);
        if (!err) chk({tag, " acc"}, {io_mem_we, io_mem_be, io_mem_addr}, {we, exp_be, a});
        if (!err && we) chk({tag, " wdata"}, io_mem_wdata, exp_wd);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clock);
            io_lsu_req_valid = 1'b0;
            en_seen = en_seen | io_mem_en;
            if (io_lsu_resp_valid) begin
                cnt++;
                if (lat == 0) begin lat = k; d = io_lsu_resp_data; e = io_lsu_resp_err; end
            end
        end
        chk({tag, " lat"}, lat, (err || we) ? 1 : 2);
        chk({tag, " pulses"}, cnt, 1);
        chk({tag, " err"}, e, err);
        chk({tag, " data"}, d, (err || we) ? 32'h0 : v);
        if (err) chk({tag, " no_access"}, en_seen, 0);
        if (we && !err) for (int i = 0; i < nb; i++) refm[a][8*(off+i) +: 8] = wd[8*i +: 8];
    endtask

    initial begin
        logic [5:0] got, expo;
        logic [63:0] ad;
        int pl, pi, lc, ic, n;
        bit last_l, g_l, both, seen;
        io_if_req_valid = 1'b1;
        io_lsu_req_valid = 1'b1;
        io_lsu_req_addr = 64'h204;
        io_lsu_req_func3 = 3'd2;
        pl_en = 1'b1;
        for (int w = 0; w <= 16'hC4; w++) begin
            @(negedge clock);
            pl_a = (w == 16'hC4) ? AW'(16'h3FFF) : AW'(w);
            pl_d = (pl_a == 14'h40) ? 32'h00500093 : (pl_a == 14'h41) ? 32'h00100113 : $urandom();
            refm[pl_a] = pl_d;
            if (io_mem_en) seen = 1;
        end
        @(negedge clock);
        pl_en = 1'b0;
        chk("reset_en_during_reset", seen, 0);
        chk("reset_ready", {io_if_req_ready, io_lsu_req_ready}, 0);
        chk("reset_mem", {io_mem_en, io_mem_we, io_mem_be, io_mem_addr, io_mem_wdata}, 0);
        chk("reset_resp", {io_if_resp_valid, io_lsu_resp_valid, io_lsu_resp_err, io_busy}, 0);
        chk("reset_data", {io_if_resp_inst_0, io_if_resp_inst_1}, 0);
        chk("reset_ldata", io_lsu_resp_data, 0);
        io_if_req_valid = 1'b0;
        io_lsu_req_valid = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        fetch("fetch100", 64'h100);
        fetch("fetch_wrap", 64'hFFFC);
        lsu("sb203", 64'h203, 1, 3'b000, 32'h000000A5);
        chk("sb203_ref", refm[14'h80][31:24], 8'hA5);
        lsu("lb203", 64'h203, 0, 3'b000, 32'h0);
        lsu("lbu203", 64'h203, 0, 3'b100, 32'h0);
        lsu("lw302", 64'h302, 0, 3'b010, 32'h0);
        lsu("st011", 64'h300, 1, 3'b011, 32'h12345678);
        lsu("sh202", 64'h202, 1, 3'b001, 32'h0000BEEF);
        lsu("lh202", 64'h202, 0, 3'b001, 32'h0);

        // abort a fetch in IF_WAIT with both requesters still asserting
        @(negedge clock);
        io_if_req_valid = 1'b1;
        io_if_req_addr = 64'h10;
        #1;
        n = 0;
        while (!io_if_req_ready && n < 20) begin @(negedge clock); #1; n++; end
        chk("rst_fetch_grant", io_if_req_ready, 1);
        @(negedge clock);
        @(negedge clock);
        chk("rst_busy_before", io_busy, 1);
        reset = 1'b1;
        io_lsu_req_valid = 1'b1;
        #1;
        chk("rst_busy", io_busy, 0);
        chk("rst_mem_en", {io_mem_en, io_mem_be}, 0);
        chk("rst_ready", {io_if_req_ready, io_lsu_req_ready}, 0);
        seen = 0;
        for (int k = 0; k < 4; k++) begin @(negedge clock); seen = seen | io_if_resp_valid | io_mem_en; end
        chk("rst_no_resp", seen, 0);
        io_if_req_valid = 1'b0;
        io_lsu_req_valid = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        fetch("fetch_after_rst", 64'h20);

        // conflict: three requests from each side, from a fresh last-grant state
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        pl = 3; pi = 3; last_l = 0; expo = '0;
        for (int g = 0; g < 6; g++) begin
`ifdef MEM_ARB_RR_EN
            g_l = pl > 0 && (pi == 0 || !last_l);
`else
            g_l = pl > 0;
`endif
            expo = {expo[4:0], g_l};
            last_l = g_l;
            if (g_l) pl--; else pi--;
        end
        io_if_req_valid = 1'b1;
        io_if_req_addr = 64'h0;
        io_lsu_req_valid = 1'b1;
        io_lsu_req_addr = 64'h8;
        io_lsu_req_we = 1'b0;
        io_lsu_req_func3 = 3'b010;
        got = '0; lc = 0; ic = 0; n = 0; both = 0;
        while (lc + ic < 6 && n < 100) begin
            #1;
            if (io_if_req_ready && io_lsu_req_ready) both = 1;
            if (io_lsu_req_ready) begin got = {got[4:0], 1'b1}; lc++; end
            else if (io_if_req_ready) begin got = {got[4:0], 1'b0}; ic++; end
            @(negedge clock);
            n++;
            if (lc == 3) io_lsu_req_valid = 1'b0;
            if (ic == 3) io_if_req_valid = 1'b0;
        end
        io_if_req_valid = 1'b0;
        io_lsu_req_valid = 1'b0;
        chk("conflict_count", lc + ic, 6);
        chk("conflict_excl", both, 0);
        chk("conflict_order", got, expo);
        repeat (6) @(negedge clock);

        for (int r = 0; r < 80; r++) begin
            ad = {$urandom(), $urandom()};
            if ($urandom_range(0, 3) == 0) begin
                ad[15:0] = {8'h0, 6'($urandom_range(0, 62)), 2'($urandom())};
                fetch("rnd_fetch", ad);
            end else begin
                ad[15:0] = {8'h0, 6'($urandom()), 2'($urandom())};
                lsu("rnd_lsu", ad, 1'($urandom()), 3'($urandom()), $urandom());
            end
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
